// File: rtl/burst_mem_if.sv
// Burst request / beat stream bundle for burst_mem.
// master issues bursts and consumes beats; slave is the memory.
interface burst_mem_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = ADDR_W + 1
);
    logic              burst_start;
    logic [ADDR_W-1:0] burst_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              burst_busy;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output burst_start, burst_addr, burst_len, out_ready,
        input  burst_busy, out_valid, out_data, out_last
    );

    modport slave (
        input  burst_start, burst_addr, burst_len, out_ready,
        output burst_busy, out_valid, out_data, out_last
    );
endinterface

// File: rtl/burst_mem.sv
// Single-clock memory: write port, 1-cycle random read port and a
// burst-read engine streaming a contiguous range over valid/ready.
module burst_mem #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    burst_mem_if.slave        bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, RUN} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] faddr;
    logic [LEN_W-1:0]  fcnt;
    logic              f_valid;
    logic              f_last;
    logic [DATA_W-1:0] f_data;
    logic              out_adv;
    logic              fetch;

    assign bus.burst_busy = (state == RUN);

    // Output register frees up when empty or its beat is taken.
    assign out_adv = !bus.out_valid || bus.out_ready;
    assign fetch   = (state == RUN) && (fcnt != '0)
                   && (!f_valid || out_adv);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            faddr         <= '0;
            fcnt          <= '0;
            f_valid       <= 1'b0;
            f_last        <= 1'b0;
            f_data        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.burst_start && bus.burst_len != '0) begin
                        state <= RUN;
                        faddr <= bus.burst_addr;
                        fcnt  <= bus.burst_len;
                    end
                end
                RUN: begin
                    if (fetch) begin
                        f_data <= mem[faddr];
                        f_last <= (fcnt == LEN_W'(1));
                        faddr  <= faddr + ADDR_W'(1);
                        fcnt   <= fcnt - LEN_W'(1);
                    end
                    if (out_adv) begin
                        bus.out_valid <= f_valid;
                        bus.out_last  <= f_valid && f_last;
                        if (f_valid)
                            bus.out_data <= f_data;
                    end
                    f_valid <= fetch || (f_valid && !out_adv);
                    if (bus.out_valid && bus.out_ready && bus.out_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
